// File: rtl/game_controller_if.sv
// Movement handshake between the 2048 game controller (master) and the movement block (slave).
// Cells are 12-bit tile values indexed [row][col].
interface game_controller_if;
    logic [3:0]              direction;
    logic                    ready;
    logic [3:0][3:0][11:0]   matrix;
    logic [3:0][3:0][11:0]   moved_matrix;

    modport master (
        output direction,
        output matrix,
        input  ready,
        input  moved_matrix
    );

    modport slave (
        input  direction,
        input  matrix,
        output ready,
        output moved_matrix
    );
endinterface

// File: rtl/game_controller.sv
// 2048 game controller: owns the board, issues direction requests, latches moves,
// spawns tiles from an LFSR and tracks move count and win/lose flags.
module game_controller #(
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter int          TIMEOUT   = 64,
    parameter int          WIN_VALUE = 2048
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [3:0]               btn,
    game_controller_if.master        mv,
    output logic [15:0]              move_count,
    output logic                     game_won,
    output logic                     game_over,
    output logic                     timeout_err
);

    typedef logic [3:0][3:0][11:0] board_t;

    typedef enum logic [2:0] {
        S_INIT, S_SPAWN, S_CHECK, S_IDLE, S_REQ, S_LATCH, S_WAIT_REL, S_OVER
    } state_e;

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [11:0] WIN_CELL = 12'(WIN_VALUE);

    function automatic logic board_won(input board_t b);
        logic w;
        w = 1'b0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (b[r][c] >= WIN_CELL) w = 1'b1;
        return w;
    endfunction

    // Stuck means no empty cell and no equal horizontal or vertical neighbours.
    function automatic logic board_stuck(input board_t b);
        logic s;
        s = 1'b1;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (b[r][c] == 12'd0) s = 1'b0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 3; c++)
                if (b[r][c] == b[r][c+1]) s = 1'b0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 4; c++)
                if (b[r][c] == b[r+1][c]) s = 1'b0;
        return s;
    endfunction

    state_e         state_q, state_d;
    board_t         board_q, board_d;
    logic [3:0]     dir_q, dir_d;
    logic [15:0]    cnt_q, cnt_d;
    logic           won_q, won_d;
    logic           over_q, over_d;
    logic           tout_q, tout_d;
    logic [15:0]    lfsr_q, lfsr_d;
    logic [1:0]     sl_q, sl_d;
    logic [3:0]     btn_prev_q, btn_prev_d;
    logic [TW-1:0]  tcnt_q, tcnt_d;
    logic [3:0]     scan_idx_q, scan_idx_d;
    logic [4:0]     scan_cnt_q, scan_cnt_d;

    logic           press_s;
    logic [3:0]     cur_idx_s;

    assign press_s   = (btn_prev_q == 4'd0) && (btn != 4'd0) && ((btn & (btn - 4'd1)) == 4'd0);
    // The first scan cycle starts wherever the LFSR currently points.
    assign cur_idx_s = (scan_cnt_q == 5'd0) ? lfsr_q[3:0] : scan_idx_q;

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_INIT;
            board_q    <= '0;
            dir_q      <= 4'd0;
            cnt_q      <= 16'd0;
            won_q      <= 1'b0;
            over_q     <= 1'b0;
            tout_q     <= 1'b0;
            lfsr_q     <= SEED;
            sl_q       <= 2'd2;
            btn_prev_q <= 4'd0;
            tcnt_q     <= '0;
            scan_idx_q <= 4'd0;
            scan_cnt_q <= 5'd0;
        end else begin
            state_q    <= state_d;
            board_q    <= board_d;
            dir_q      <= dir_d;
            cnt_q      <= cnt_d;
            won_q      <= won_d;
            over_q     <= over_d;
            tout_q     <= tout_d;
            lfsr_q     <= lfsr_d;
            sl_q       <= sl_d;
            btn_prev_q <= btn_prev_d;
            tcnt_q     <= tcnt_d;
            scan_idx_q <= scan_idx_d;
            scan_cnt_q <= scan_cnt_d;
        end
    end

    // Next-state and output logic for the game FSM.
    always_comb begin
        state_d    = state_q;
        board_d    = board_q;
        dir_d      = dir_q;
        cnt_d      = cnt_q;
        won_d      = won_q;
        over_d     = over_q;
        tout_d     = 1'b0;
        lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        sl_d       = sl_q;
        btn_prev_d = btn;
        tcnt_d     = tcnt_q;
        scan_idx_d = scan_idx_q;
        scan_cnt_d = scan_cnt_q;

        case (state_q)
            S_INIT: begin
                if (sl_q != 2'd0) begin
                    sl_d       = sl_q - 2'd1;
                    scan_cnt_d = 5'd0;
                    state_d    = S_SPAWN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SPAWN: begin
                if (board_q[cur_idx_s[3:2]][cur_idx_s[1:0]] == 12'd0) begin
                    board_d[cur_idx_s[3:2]][cur_idx_s[1:0]] = (lfsr_q[7:4] == 4'd0) ? 12'd4 : 12'd2;
                    state_d = S_CHECK;
                end else if (scan_cnt_q == 5'd15) begin
                    state_d = S_CHECK;
                end else begin
                    scan_idx_d = cur_idx_s + 4'd1;
                    scan_cnt_d = scan_cnt_q + 5'd1;
                end
            end
            S_CHECK: begin
                won_d = won_q | board_won(board_q);
                if (board_stuck(board_q)) begin
                    over_d  = 1'b1;
                    state_d = S_OVER;
                end else if (sl_q != 2'd0) begin
                    state_d = S_INIT;
                end else begin
                    state_d = S_WAIT_REL;
                end
            end
            S_IDLE: begin
                dir_d = 4'd0;
                if (press_s) begin
                    dir_d   = btn;
                    tcnt_d  = '0;
                    state_d = S_REQ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                if (mv.ready) begin
                    dir_d   = 4'd0;
                    state_d = S_LATCH;
                end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
                    dir_d   = 4'd0;
                    tout_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tcnt_d = tcnt_q + TW'(1'b1);
                end
            end
            S_LATCH: begin
                dir_d = 4'd0;
                if (mv.moved_matrix != board_q) begin
                    board_d    = mv.moved_matrix;
                    cnt_d      = cnt_q + 16'd1;
                    scan_cnt_d = 5'd0;
                    state_d    = S_SPAWN;
                end else begin
                    state_d = S_WAIT_REL;
                end
            end
            S_WAIT_REL: begin
                if (btn == 4'd0) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT_REL;
                end
            end
            S_OVER: begin
                dir_d   = 4'd0;
                state_d = S_OVER;
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    assign mv.direction = dir_q;
    assign mv.matrix    = board_q;
    assign move_count   = cnt_q;
    assign game_won     = won_q;
    assign game_over    = over_q;
    assign timeout_err  = tout_q;

endmodule

// File: tb/tb_game_controller.sv
// Directed self-checking bench for game_controller; the bench plays the movement block.
module tb_game_controller;

    typedef logic [3:0][3:0][11:0] board_t;

    logic        clk;
    logic        rst;
    logic [3:0]  btn;
    logic [15:0] move_count;
    logic        game_won;
    logic        game_over;
    logic        timeout_err;

    int errors = 0;
    int checks = 0;
    int exp_cnt = 0;

    game_controller_if mv_if ();

    game_controller dut (
        .clk         (clk),
        .rst         (rst),
        .btn         (btn),
        .mv          (mv_if),
        .move_count  (move_count),
        .game_won    (game_won),
        .game_over   (game_over),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Number of freshly spawned tiles relative to base, or -1 if any difference is not a legal spawn.
    function automatic int new_tiles(input board_t b, input board_t base);
        int n;
        n = 0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (b[r][c] != base[r][c]) begin
                    if (base[r][c] == 12'd0 && (b[r][c] == 12'd2 || b[r][c] == 12'd4)) n++;
                    else return -1;
                end
        return n;
    endfunction

    // One full request: press, hold, answer with ret, release.
    task automatic do_move(input logic [3:0] b, input board_t ret);
        btn = b;
        tick(1);
        check("req_dir", mv_if.direction, b);
        tick(2);
        check("req_hold", mv_if.direction, b);
        mv_if.moved_matrix = ret;
        mv_if.ready = 1'b1;
        tick(1);
        check("latch_dir", mv_if.direction, 4'd0);
        tick(1);
        mv_if.ready = 1'b0;
        tick(20);
        btn = 4'd0;
        tick(3);
    endtask

    board_t P, R, F, W, C;
    int n_dir;
    int n_tout;

    initial begin
        P = '0; P[0][0] = 12'd2; P[0][1] = 12'd2; P[1][0] = 12'd4; P[2][0] = 12'd4; P[3][0] = 12'd4;
        R = '0;
        for (int r = 0; r < 4; r++) R[r][0] = 12'd4;
        F[0] = {12'd8,   12'd4,    12'd2,   12'd2};
        F[1] = {12'd128, 12'd64,   12'd32,  12'd16};
        F[2] = {12'd2,   12'd1024, 12'd512, 12'd256};
        F[3] = {12'd32,  12'd16,   12'd8,   12'd4};
        W = F; W[3][3] = 12'd2048;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                C[r][c] = (((r + c) % 2) == 0) ? 12'd2 : 12'd4;

        rst = 1'b0;
        btn = 4'd0;
        mv_if.ready = 1'b0;
        mv_if.moved_matrix = '0;
        tick(3);
        check("rst_dir",   mv_if.direction, 4'd0);
        check("rst_board", mv_if.matrix, 192'd0);
        check("rst_cnt",   move_count, 16'd0);
        check("rst_flags", {game_won, game_over, timeout_err}, 3'b000);

        // Two starting tiles.
        rst = 1'b1;
        tick(40);
        check("init_tiles", new_tiles(mv_if.matrix, '0), 2);
        check("init_dir",   mv_if.direction, 4'd0);
        check("init_cnt",   move_count, 16'd0);
        check("init_flags", {game_won, game_over}, 2'b00);

        // Preload P, then move left to R: each adds one spawn.
        do_move(4'b0100, P); exp_cnt++;
        check("pre_tiles", new_tiles(mv_if.matrix, P), 1);
        check("pre_cnt",   move_count, 16'(exp_cnt));
        do_move(4'b0100, R); exp_cnt++;
        check("left_tiles", new_tiles(mv_if.matrix, R), 1);
        check("left_cnt",   move_count, 16'(exp_cnt));

        // Full board F: no spawn possible; then identical return is a no-op.
        do_move(4'b0001, F); exp_cnt++;
        check("full_board", mv_if.matrix, F);
        check("full_cnt",   move_count, 16'(exp_cnt));
        check("full_over",  game_over, 1'b0);
        do_move(4'b0010, F);
        check("same_board", mv_if.matrix, F);
        check("same_cnt",   move_count, 16'(exp_cnt));

        // Multi-bit press ignored; held press yields only one request.
        btn = 4'b0101;
        tick(4);
        check("multi_dir", mv_if.direction, 4'd0);
        btn = 4'd0;
        tick(1);
        btn = 4'b0001;
        tick(1);
        check("held_dir", mv_if.direction, 4'b0001);
        mv_if.moved_matrix = F;
        mv_if.ready = 1'b1;
        tick(2);
        mv_if.ready = 1'b0;
        n_dir = 0;
        for (int i = 0; i < 30; i++) begin
            if (mv_if.direction != 4'd0) n_dir++;
            tick(1);
        end
        check("held_once", n_dir, 0);
        btn = 4'd0;
        tick(2);

        // ready while idle must not touch the board.
        mv_if.moved_matrix = C;
        mv_if.ready = 1'b1;
        tick(5);
        mv_if.ready = 1'b0;
        check("idle_rdy_board", mv_if.matrix, F);
        check("idle_rdy_cnt",   move_count, 16'(exp_cnt));

        // Timeout: direction valid for exactly 64 cycles, one-cycle error pulse.
        btn = 4'b1000;
        tick(1);
        n_dir = 0;
        n_tout = 0;
        for (int i = 0; i < 200; i++) begin
            if (mv_if.direction != 4'd0) n_dir++;
            if (timeout_err) n_tout++;
            tick(1);
        end
        check("tout_len",   n_dir, 64);
        check("tout_pulse", n_tout, 1);
        check("tout_board", mv_if.matrix, F);
        check("tout_cnt",   move_count, 16'(exp_cnt));
        btn = 4'd0;
        tick(2);

        // Win does not freeze play.
        do_move(4'b0001, W); exp_cnt++;
        check("won_flag", {game_won, game_over}, 2'b10);
        check("won_board", mv_if.matrix, W);

        // Stuck checkerboard ends the game.
        do_move(4'b0010, C); exp_cnt++;
        check("over_flag", {game_won, game_over}, 2'b11);
        check("over_cnt",  move_count, 16'(exp_cnt));
        btn = 4'b0001;
        tick(1);
        check("over_dir1", mv_if.direction, 4'd0);
        tick(5);
        check("over_dir2", mv_if.direction, 4'd0);
        check("over_board", mv_if.matrix, C);
        btn = 4'd0;
        tick(2);

        // Reset mid-request drops direction on the same edge.
        rst = 1'b0;
        tick(1);
        check("rst2_flags", {game_won, game_over, timeout_err}, 3'b000);
        check("rst2_board", mv_if.matrix, 192'd0);
        rst = 1'b1;
        tick(40);
        btn = 4'b0010;
        tick(1);
        check("rst3_req", mv_if.direction, 4'b0010);
        rst = 1'b0;
        tick(1);
        check("rst3_dir", mv_if.direction, 4'd0);
        check("rst3_cnt", move_count, 16'd0);
        btn = 4'd0;
        rst = 1'b1;
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/game_controller.md
Name: game_controller

Overview:
- Initiator side of the 2048 movement interface.
- Owns the 4x4 board register and turns player button presses into direction requests to the movement FSM.
- Latches the returned moved_matrix, spawns a new tile from an LFSR, then evaluates win/lose.
- Sits between the button debouncer and the movement block; its board output feeds both movement.matrix and the display.

Parameters:
SEED, 16'hACE1, LFSR reset value; must be nonzero.
TIMEOUT, 64, max cycles to wait for ready before aborting a request.
WIN_VALUE, 2048, tile value that sets game_won.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-low reset
btn  in  4  debounced buttons: [0]=up, [1]=down, [2]=left, [3]=right
ready  in  1  movement done; moved_matrix valid while high
moved_matrix  in  12 x [3:0][3:0]  result from movement block
direction  out  4  one-hot request to movement; 4'b0000 = no request
matrix  out  12 x [3:0][3:0]  current board, driven to movement and display
move_count  out  16  accepted moves that changed the board
game_won  out  1  sticky; a tile >= WIN_VALUE exists
game_over  out  1  sticky; no empty cell and no equal orthogonal neighbours
timeout_err  out  1  one-cycle pulse when a request times out

Behaviour:
- Reset (rst=0 at a clock edge): all board cells 0, direction 0, move_count 0, game_won/game_over/timeout_err 0, LFSR=SEED, state INIT, spawn_left=2. Reset mid-request drops direction to 0 on the same edge.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Shifts every cycle, in all states.
- Button edge detect: a request fires on the cycle btn goes from 4'b0000 to exactly one bit set. Multi-bit patterns are ignored. Presses outside IDLE are ignored.
- INIT: go to SPAWN twice (spawn_left counts down), then IDLE. Result: two starting tiles.
- IDLE: direction=0. On a valid press, load direction = the pressed one-hot, clear the timeout counter, go to REQ.
- REQ:
  - Hold direction and matrix stable.
  - ready=1: go to LATCH.
  - Counter reaches TIMEOUT-1 with ready still 0: direction=0, pulse timeout_err, go to IDLE; board unchanged.
- LATCH (1 cycle):
  - direction=0.
  - If moved_matrix differs from the board: board <= moved_matrix, move_count += 1 (wraps at 16'hFFFF to 0), go to SPAWN.
  - Otherwise go to WAIT_REL; no spawn, no count.
- SPAWN:
  - Start index i = lfsr[3:0]; cell (row=i[3:2], col=i[1:0]). Scan one cell per cycle, i+1 mod 16 wrapping, max 16 cycles.
  - First empty cell found gets 4 if lfsr[7:4]==0, else 2.
  - No empty cell found: place nothing.
  - Then go to CHECK.
- CHECK (1 cycle):
  - game_won set if any cell >= WIN_VALUE.
  - game_over set if no cell is 0 and no horizontally or vertically adjacent pair is equal.
  - Next state: INIT continuation if spawn_left>0, else WAIT_REL.
- WAIT_REL: stay until btn==0, then IDLE (one move per press).
- OVER: entered from CHECK when game_over=1. direction stays 0, board frozen, buttons ignored; exit only via reset. game_won does not freeze play.
- ready seen high while in IDLE is ignored.
- Latency: press edge to direction valid = 1 cycle. ready to board update = 1 cycle. Spawn = 1 to 16 cycles.

Test Plan:
1. Reset, release rst, run 40 cycles, btn=0 -> exactly two nonzero cells, each 2 or 4; direction=0; move_count=0; flags 0.
2. Force board {2,2,0,0 / 4,0,0,0 / 4,0,0,0 / 4,0,0,0}, press btn=4'b0100, model returns ready with {4,0,0,0 / 4,0,0,0 / 4,0,0,0 / 4,0,0,0} -> direction=4'b0100 until ready; board = returned matrix plus exactly one new 2/4 in a previously empty cell; move_count=1.
3. Model returns moved_matrix identical to the board -> no new tile, move_count unchanged, back to IDLE after btn release.
4. btn=4'b0101, then btn held 4'b0001 across two moves -> no request for 0101; only one request for the held press.
5. Press with ready held 0 (TIMEOUT=64) -> direction drops at request cycle 64, timeout_err high for exactly 1 cycle, board unchanged.
6. Board preloaded with a checkerboard of 2/4 and no zeros, trivial move -> game_over=1, further presses produce no direction. Separate run: returned board containing 2048 -> game_won=1.
